elg_encrypt_ctrl: RTL and testbench

Sequencer for EC-ElGamal encryption over a 256-bit prime field (p mod 4 = 3). It accepts one (priv, message, G, Q) request and embeds the message as a curve point M. It then drives a single shared scalar-multiply engine twice (C = priv·G, S = priv·Q) and a point-add engine once (D = M + S). Sits between the host/testbench request path and the datapath engines; contains no field arithmetic itself.

---
 rtl/elg_pkg.sv | 37 +++
 rtl/elg_embed_ctr.sv | 39 +++
 rtl/elg_encrypt_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_elg_encrypt_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elg_pkg.sv
// Shared types and constants for the EC-ElGamal encryption sequencer.
// Holds the field width, the size of the embed retry field, the FSM state
// type, the affine point payload, and the x-candidate formation helper.
package elg_pkg;

  localparam int unsigned WIDTH    = 256;
  localparam int unsigned EMB_BITS = 8;
  localparam int unsigned MSG_BITS = WIDTH - EMB_BITS;

  // Curve coefficient b in y^2 = x^3 + b; the embed engine evaluates it.
  localparam logic [WIDTH-1:0] CURVE_B = WIDTH'(7);

  typedef enum logic [3:0] {
    IDLE,
    EMBED,
    EMB_WAIT,
    MUL_C,
    MUL_C_WAIT,
    MUL_S,
    MUL_S_WAIT,
    ADD,
    ADD_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } point_t;

  // Koblitz candidate: message in the high bits, retry counter in the low bits.
  function automatic logic [WIDTH-1:0] embed_x(input logic [MSG_BITS-1:0] msg,
                                               input logic [EMB_BITS-1:0] j);
    return {msg, j};
  endfunction

endpackage

// File: rtl/elg_embed_ctr.sv
// Koblitz retry counter and x-candidate formation.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          restart the attempt count at zero
//   inc          advance to the next attempt (saturates at the last one)
//   msg          retained message bits
//   x_cand_c     current candidate x (combinational)
//   last_c       current attempt is the final one (combinational)
module elg_embed_ctr
  import elg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  input  logic [MSG_BITS-1:0] msg,
  output logic [WIDTH-1:0]    x_cand_c,
  output logic                last_c
);

  localparam logic [EMB_BITS-1:0] J_MAX = '1;

  logic [EMB_BITS-1:0] j;

  // Attempt counter; holds at J_MAX so it never wraps back to a used value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j <= '0;
    end else if (clr) begin
      j <= '0;
    end else if (inc && !last_c) begin
      j <= j + EMB_BITS'(1);
    end
  end

  assign last_c   = (j == J_MAX);
  assign x_cand_c = embed_x(msg, j);

endmodule

// File: rtl/elg_encrypt_ctrl.sv
// EC-ElGamal encryption sequencer: embeds the message as a point M, then
// computes C = priv*G, S = priv*Q and D = M + S on external engines.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready, priv, message, Gx, Gy, Qx, Qy   request
//   resp_valid/resp_ready, Cx, Cy, Dx, Dy, error         response
//   emb_*                           square-root / embed engine handshake
//   mul_*                           scalar-multiply engine handshake
//   add_*                           point-add engine handshake
module elg_encrypt_ctrl
  import elg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] priv,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] Gx,
  input  logic [WIDTH-1:0] Gy,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] Cx,
  output logic [WIDTH-1:0] Cy,
  output logic [WIDTH-1:0] Dx,
  output logic [WIDTH-1:0] Dy,
  output logic             error,
  output logic             emb_start,
  output logic [WIDTH-1:0] emb_x,
  input  logic             emb_done,
  input  logic             emb_ok,
  input  logic [WIDTH-1:0] emb_y,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_k,
  output logic [WIDTH-1:0] mul_Px,
  output logic [WIDTH-1:0] mul_Py,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_Rx,
  input  logic [WIDTH-1:0] mul_Ry,
  output logic             add_start,
  output logic [WIDTH-1:0] add_Px,
  output logic [WIDTH-1:0] add_Py,
  output logic [WIDTH-1:0] add_Qx,
  output logic [WIDTH-1:0] add_Qy,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_Rx,
  input  logic [WIDTH-1:0] add_Ry
);

  state_t              state;
  logic [WIDTH-1:0]    priv_q;
  logic [MSG_BITS-1:0] msg_q;
  point_t              g_q, q_q, m_q, s_q;

  logic                req_fire;
  logic                emb_fail;
  logic [WIDTH-1:0]    x_cand_c;
  logic                last_c;

  // Message bits above the embed field are dropped by design.
  logic                msg_unused;
  assign msg_unused = ^message[WIDTH-1:MSG_BITS];

  assign req_fire = (state == IDLE) && req_valid && req_ready;
  // A done that coincides with our own start pulse is too early to be ours.
  assign emb_fail = (state == EMB_WAIT) && emb_done && !emb_start && !emb_ok;

  elg_embed_ctr u_embed_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (req_fire),
    .inc      (emb_fail),
    .msg      (msg_q),
    .x_cand_c (x_cand_c),
    .last_c   (last_c)
  );

  // Sequencer: state, operand registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      error      <= 1'b0;
      Cx         <= '0;
      Cy         <= '0;
      Dx         <= '0;
      Dy         <= '0;
      emb_start  <= 1'b0;
      emb_x      <= '0;
      mul_start  <= 1'b0;
      mul_k      <= '0;
      mul_Px     <= '0;
      mul_Py     <= '0;
      add_start  <= 1'b0;
      add_Px     <= '0;
      add_Py     <= '0;
      add_Qx     <= '0;
      add_Qy     <= '0;
      priv_q     <= '0;
      msg_q      <= '0;
      g_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      emb_start <= 1'b0;
      mul_start <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_fire) begin
            req_ready <= 1'b0;
            error     <= 1'b0;
            priv_q    <= priv;
            msg_q     <= message[MSG_BITS-1:0];
            g_q       <= '{x: Gx, y: Gy};
            q_q       <= '{x: Qx, y: Qy};
            state     <= EMBED;
          end
        end
        EMBED: begin
          emb_x     <= x_cand_c;
          emb_start <= 1'b1;
          state     <= EMB_WAIT;
        end
        EMB_WAIT: begin
          if (emb_done && !emb_start) begin
            if (emb_ok) begin
              m_q   <= '{x: emb_x, y: emb_y};
              state <= MUL_C;
            end else if (!last_c) begin
              state <= EMBED;
            end else begin
              error      <= 1'b1;
              Cx         <= '0;
              Cy         <= '0;
              Dx         <= '0;
              Dy         <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end
        end
        MUL_C: begin
          mul_k     <= priv_q;
          mul_Px    <= g_q.x;
          mul_Py    <= g_q.y;
          mul_start <= 1'b1;
          state     <= MUL_C_WAIT;
        end
        MUL_C_WAIT: begin
          if (mul_done && !mul_start) begin
            Cx    <= mul_Rx;
            Cy    <= mul_Ry;
            state <= MUL_S;
          end
        end
        MUL_S: begin
          mul_k     <= priv_q;
          mul_Px    <= q_q.x;
          mul_Py    <= q_q.y;
          mul_start <= 1'b1;
          state     <= MUL_S_WAIT;
        end
        MUL_S_WAIT: begin
          if (mul_done && !mul_start) begin
            s_q   <= '{x: mul_Rx, y: mul_Ry};
            state <= ADD;
          end
        end
        ADD: begin
          add_Px    <= m_q.x;
          add_Py    <= m_q.y;
          add_Qx    <= s_q.x;
          add_Qy    <= s_q.y;
          add_start <= 1'b1;
          state     <= ADD_WAIT;
        end
        ADD_WAIT: begin
          if (add_done && !add_start) begin
            Dx         <= add_Rx;
            Dy         <= add_Ry;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elg_encrypt_ctrl.sv
// Directed bench for elg_encrypt_ctrl with behavioural engine models.
// Engines use a toy linear group (k*P and P+Q taken componentwise mod 2^256),
// so C = k*G, D = M + k*Q can be written directly as expected constants.
module tb_elg_encrypt_ctrl;

  localparam int unsigned W = 256;
  localparam logic [W-1:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [W-1:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam int LAT = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_ready;
  logic [W-1:0] priv = '0, message = '0, gx_i = '0, gy_i = '0, qx_i = '0, qy_i = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [W-1:0] Cx, Cy, Dx, Dy;
  logic         error;
  logic         emb_start, emb_done, emb_ok;
  logic [W-1:0] emb_x, emb_y;
  logic         mul_start, mul_done;
  logic [W-1:0] mul_k, mul_Px, mul_Py, mul_Rx, mul_Ry;
  logic         add_start, add_done;
  logic [W-1:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;

  logic stray_mul = 1'b0, stray_add = 1'b0;
  logic mul_done_m, add_done_m;
  assign mul_done = mul_done_m | stray_mul;
  assign add_done = add_done_m | stray_add;

  elg_encrypt_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .priv(priv), .message(message), .Gx(gx_i), .Gy(gy_i), .Qx(qx_i), .Qy(qy_i),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .Cx(Cx), .Cy(Cy), .Dx(Dx), .Dy(Dy), .error(error),
    .emb_start(emb_start), .emb_x(emb_x), .emb_done(emb_done), .emb_ok(emb_ok), .emb_y(emb_y),
    .mul_start(mul_start), .mul_k(mul_k), .mul_Px(mul_Px), .mul_Py(mul_Py),
    .mul_done(mul_done), .mul_Rx(mul_Rx), .mul_Ry(mul_Ry),
    .add_start(add_start), .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx), .add_Qy(add_Qy),
    .add_done(add_done), .add_Rx(add_Rx), .add_Ry(add_Ry)
  );

  // ---------------- engine models ----------------
  int acc_j = 0;          // embed accepts when candidate low byte >= acc_j
  int emb_cnt = 0, mul_cnt = 0, add_cnt = 0, unstable = 0;
  logic [7:0]   emb_log [512];
  logic [W-1:0] mul_k_log [16], mul_px_log [16];
  logic [W-1:0] add_px_log [16], add_py_log [16], add_qx_log [16];

  logic         emb_busy, mul_busy, add_busy;
  int           emb_tmr, mul_tmr, add_tmr;
  logic [W-1:0] e_x, m_k, m_px, m_py, a_px, a_py, a_qx, a_qy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emb_busy <= 1'b0; emb_done <= 1'b0; emb_ok <= 1'b0; emb_y <= '0; emb_tmr <= 0; e_x <= '0;
    end else begin
      emb_done <= 1'b0;
      if (emb_start) begin
        emb_busy <= 1'b1; emb_tmr <= LAT; e_x <= emb_x;
        emb_log[emb_cnt] <= emb_x[7:0];
        emb_cnt <= emb_cnt + 1;
      end else if (emb_busy) begin
        if (emb_x != e_x) unstable <= unstable + 1;
        if (emb_tmr <= 1) begin
          emb_busy <= 1'b0; emb_done <= 1'b1;
          emb_ok   <= (int'(e_x[7:0]) >= acc_j);
          emb_y    <= ~e_x;
        end else emb_tmr <= emb_tmr - 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0; mul_done_m <= 1'b0; mul_Rx <= '0; mul_Ry <= '0; mul_tmr <= 0;
      m_k <= '0; m_px <= '0; m_py <= '0;
    end else begin
      mul_done_m <= 1'b0;
      if (mul_start) begin
        mul_busy <= 1'b1; mul_tmr <= LAT; m_k <= mul_k; m_px <= mul_Px; m_py <= mul_Py;
        mul_k_log[mul_cnt] <= mul_k; mul_px_log[mul_cnt] <= mul_Px;
        mul_cnt <= mul_cnt + 1;
      end else if (mul_busy) begin
        if (mul_k != m_k || mul_Px != m_px || mul_Py != m_py) unstable <= unstable + 1;
        if (mul_tmr <= 1) begin
          mul_busy <= 1'b0; mul_done_m <= 1'b1;
          mul_Rx <= m_k * m_px; mul_Ry <= m_k * m_py;
        end else mul_tmr <= mul_tmr - 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_busy <= 1'b0; add_done_m <= 1'b0; add_Rx <= '0; add_Ry <= '0; add_tmr <= 0;
      a_px <= '0; a_py <= '0; a_qx <= '0; a_qy <= '0;
    end else begin
      add_done_m <= 1'b0;
      if (add_start) begin
        add_busy <= 1'b1; add_tmr <= LAT;
        a_px <= add_Px; a_py <= add_Py; a_qx <= add_Qx; a_qy <= add_Qy;
        add_px_log[add_cnt] <= add_Px; add_py_log[add_cnt] <= add_Py; add_qx_log[add_cnt] <= add_Qx;
        add_cnt <= add_cnt + 1;
      end else if (add_busy) begin
        if (add_Px != a_px || add_Qx != a_qx || add_Qy != a_qy) unstable <= unstable + 1;
        if (add_tmr <= 1) begin
          add_busy <= 1'b0; add_done_m <= 1'b1;
          add_Rx <= a_px + a_qx; add_Ry <= a_py + a_qy;
        end else add_tmr <= add_tmr - 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [W-1:0] k, input logic [W-1:0] m,
                        input logic [W-1:0] gx, input logic [W-1:0] gy,
                        input logic [W-1:0] qx, input logic [W-1:0] qy);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    check("req_ready_before_req", W'(req_ready), W'(1));
    priv = k; message = m; gx_i = gx; gy_i = gy; qx_i = qx; qy_i = qy;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_after_xfer", W'(req_ready), W'(0));
    check("error_cleared_on_xfer", W'(error), W'(0));
  endtask

  task automatic wait_resp(input int budget);
    int t;
    t = 0;
    while (!resp_valid && t < budget) begin @(negedge clk); t++; end
    check("resp_valid_seen", W'(resp_valid), W'(1));
  endtask

  task automatic wait_mul(input int target);
    int t;
    t = 0;
    while (mul_cnt < target && t < 2000) begin @(negedge clk); t++; end
    check("mul_start_seen", W'(mul_cnt), W'(target));
  endtask

  task automatic ack_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_dropped", W'(resp_valid), W'(0));
  endtask

  // ---------------- directed tests ----------------
  logic [W-1:0] qx3, qy3, msg2;
  int eb, mb, ab;

  initial begin
    qx3 = W'(3) * GX;
    qy3 = W'(3) * GY;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_resp_valid", W'(resp_valid), W'(0));
    check("rst_error", W'(error), W'(0));
    check("rst_starts", W'({emb_start, mul_start, add_start}), W'(0));
    check("rst_emb_x", emb_x, '0);
    check("rst_mul_k", mul_k, '0);
    check("rst_add_px", add_Px, '0);
    check("rst_cx", Cx, '0);
    check("rst_dy", Dy, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", W'(req_ready), W'(1));

    // Test 1: first-try embed, priv=5, message=68, Q=3G, then held response
    acc_j = 0; eb = emb_cnt; mb = mul_cnt; ab = add_cnt;
    do_req(W'(5), W'(68), GX, GY, qx3, qy3);
    wait_resp(1000);
    check("t1_emb_calls", W'(emb_cnt - eb), W'(1));
    check("t1_emb_x", emb_x, 256'h4400);
    check("t1_mul_calls", W'(mul_cnt - mb), W'(2));
    check("t1_mul0_k", mul_k_log[mb], W'(5));
    check("t1_mul0_px", mul_px_log[mb], GX);
    check("t1_mul1_k", mul_k_log[mb+1], W'(5));
    check("t1_mul1_px", mul_px_log[mb+1], qx3);
    check("t1_add_calls", W'(add_cnt - ab), W'(1));
    check("t1_add_px", add_px_log[ab], 256'h4400);
    check("t1_add_py", add_py_log[ab], ~256'h4400);
    check("t1_add_qx", add_qx_log[ab], W'(15) * GX);
    check("t1_error", W'(error), W'(0));
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      check("t1_hold_cx", Cx, W'(5) * GX);
      check("t1_hold_cy", Cy, W'(5) * GY);
      check("t1_hold_dx", Dx, 256'h4400 + W'(15) * GX);
      check("t1_hold_dy", Dy, ~256'h4400 + W'(15) * GY);
      check("t1_hold_resp_valid", W'(resp_valid), W'(1));
      check("t1_hold_req_ready", W'(req_ready), W'(0));
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("t1_no_second_req", W'(emb_cnt - eb), W'(1));
    ack_resp();

    // Test 2: embed accepts on j=3, top message byte discarded, stray add_done in MUL_C_WAIT
    acc_j = 3; eb = emb_cnt; mb = mul_cnt; ab = add_cnt;
    msg2 = 256'h1234;
    msg2[255:248] = 8'hAB;
    do_req(W'(7), msg2, GX, GY, qx3, qy3);
    wait_mul(mb + 1);
    repeat (3) @(negedge clk);
    stray_add = 1'b1;
    @(negedge clk);
    stray_add = 1'b0;
    wait_resp(2000);
    check("t2_emb_calls", W'(emb_cnt - eb), W'(4));
    check("t2_emb_j0", W'(emb_log[eb]), W'(8'h00));
    check("t2_emb_j1", W'(emb_log[eb+1]), W'(8'h01));
    check("t2_emb_j2", W'(emb_log[eb+2]), W'(8'h02));
    check("t2_emb_j3", W'(emb_log[eb+3]), W'(8'h03));
    check("t2_emb_x", emb_x, 256'h123403);
    check("t2_mul_calls", W'(mul_cnt - mb), W'(2));
    check("t2_add_calls", W'(add_cnt - ab), W'(1));
    check("t2_cx", Cx, W'(7) * GX);
    check("t2_dx", Dx, 256'h123403 + W'(21) * GX);
    check("t2_dy", Dy, ~256'h123403 + W'(21) * GY);
    check("t2_error", W'(error), W'(0));
    ack_resp();

    // Test 3: embed never succeeds -> 256 attempts, error, zeroed ciphertext
    acc_j = 1000; eb = emb_cnt; mb = mul_cnt; ab = add_cnt;
    do_req(W'(5), W'(68), GX, GY, qx3, qy3);
    wait_resp(10000);
    check("t3_emb_calls", W'(emb_cnt - eb), W'(256));
    check("t3_emb_first", W'(emb_log[eb]), W'(8'h00));
    check("t3_emb_last", W'(emb_log[eb+255]), W'(8'hFF));
    check("t3_error", W'(error), W'(1));
    check("t3_cx", Cx, '0);
    check("t3_cy", Cy, '0);
    check("t3_dx", Dx, '0);
    check("t3_dy", Dy, '0);
    check("t3_mul_calls", W'(mul_cnt - mb), W'(0));
    check("t3_add_calls", W'(add_cnt - ab), W'(0));
    ack_resp();

    // Test 4: reset during MUL_S_WAIT, stray mul_done after release
    acc_j = 0; mb = mul_cnt; ab = add_cnt;
    do_req(W'(9), W'(5), GX, GY, qx3, qy3);
    wait_mul(mb + 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_req_ready", W'(req_ready), W'(0));
    check("t4_rst_starts", W'({emb_start, mul_start, add_start}), W'(0));
    check("t4_rst_mul_k", mul_k, '0);
    check("t4_rst_mul_px", mul_Px, '0);
    check("t4_rst_emb_x", emb_x, '0);
    check("t4_rst_cx", Cx, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_mul = 1'b1;
    @(negedge clk);
    stray_mul = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_idle_req_ready", W'(req_ready), W'(1));
      check("t4_idle_resp_valid", W'(resp_valid), W'(0));
      check("t4_idle_cx", Cx, '0);
      @(negedge clk);
    end
    check("t4_no_extra_mul", W'(mul_cnt - mb), W'(2));
    check("t4_no_add", W'(add_cnt - ab), W'(0));

    // Test 5: clean request after reset, priv=2, message=1, Q=G
    acc_j = 0; eb = emb_cnt; mb = mul_cnt; ab = add_cnt;
    do_req(W'(2), W'(1), GX, GY, GX, GY);
    wait_resp(1000);
    check("t5_emb_calls", W'(emb_cnt - eb), W'(1));
    check("t5_mul_calls", W'(mul_cnt - mb), W'(2));
    check("t5_mul1_px", mul_px_log[mb+1], GX);
    check("t5_add_calls", W'(add_cnt - ab), W'(1));
    check("t5_cx", Cx, W'(2) * GX);
    check("t5_cy", Cy, W'(2) * GY);
    check("t5_dx", Dx, 256'h100 + W'(2) * GX);
    check("t5_dy", Dy, ~256'h100 + W'(2) * GY);
    check("t5_error", W'(error), W'(0));
    ack_resp();

    check("operands_stable", W'(unstable), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
